integral_image_gen: RTL and testbench
=====================================

Name: integral_image_gen

Overview:
- Parametrised integral-image generator for the pre-process chain. Sits after the grayscale stage and writes each integral-image word to the IIG BRAM.
- Generalises the fixed 8-bit / 13-bit-address / 21-bit-data generator:
  - configurable frame geometry and pixel width;
  - explicit frame-start, busy and frame-done handshake;
  - optional squared-integral output for variance normalisation in the classifier.

Parameters:
- IMG_W, 80, pixels per row.
- IMG_H, 60, rows per frame.
- PIX_W, 8, input pixel width.
- ADDR_W, 13, BRAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- II_W, 21, integral word width; equals PIX_W+ADDR_W.
- SQ_W, 29, squared-integral word width; equals 2*PIX_W+ADDR_W.

Ports:
- iClk  in  1  clock.
- iReset_n  in  1  synchronous active-low reset.
- iRun  in  1  single-cycle pulse that starts or restarts a frame.
- iInput_ready  in  1  iData is valid this cycle.
- iData  in  PIX_W  grayscale pixel, raster order.
- oWrreq  out  1  BRAM write strobe.
- oAddr  out  ADDR_W  BRAM address, equal to row*IMG_W+col.
- oData  out  II_W  integral value at (row, col).
- oSq_data  out  SQ_W  squared-integral value; 0 when the feature is disabled.
- oBusy  out  1  high while state is ACCUM.
- oFrame_done  out  1  one-cycle pulse on the last write of a frame.

Behaviour:
- Interface: reset iReset_n, synchronous, active-low; clock iClk.
- Reset values:
  - all outputs 0;
  - state IDLE;
  - col, row and row_sum 0.
  - The line buffer is not cleared; row 0 ignores it.
- FSM has two states, IDLE and ACCUM.
  - IDLE -> ACCUM on iRun.
  - ACCUM -> IDLE on acceptance of pixel (IMG_W-1, IMG_H-1).
  - iRun in ACCUM restarts the frame: col, row and row_sum are cleared and the state stays ACCUM.
- Pixel acceptance requires state==ACCUM, iInput_ready==1 and iRun==0.
  - iInput_ready in IDLE is dropped and produces no write.
  - On a cycle with both iRun and iInput_ready, iRun wins and the pixel is dropped.
- Per accepted pixel p at (row, col):
  - rs = (col==0 ? 0 : row_sum) + p
  - above = (row==0 ? 0 : lb[col])
  - ii = rs + above
  - Then: row_sum <= rs; lb[col] <= ii. The line buffer is read before it is written at the same index.
- All arithmetic is unsigned and zero-extended to II_W. No overflow is possible within the parameter constraints.
- Counters:
  - col wraps from IMG_W-1 to 0 and row increments on the wrap.
  - After (IMG_W-1, IMG_H-1), row and col return to 0.
- Latency: one cycle. In the cycle after acceptance, oWrreq=1 with registered oAddr, oData and oSq_data.
  - oWrreq is 0 in every cycle not following an acceptance.
  - oAddr and oData hold their last values when oWrreq is 0.
- oFrame_done is high in the same cycle as the write for address IMG_W*IMG_H-1.
- oBusy falls in the cycle after the last pixel is accepted, i.e. together with the final oWrreq.
- Back-to-back pixels are supported: one pixel per cycle throughput, no stalls.
- Reset mid-frame aborts the frame immediately; no further writes, no oFrame_done.

Optional Feature:
- Macro SQ_INTEGRAL_EN.
- Defined:
  - a second accumulator and line buffer, SQ_W bits wide, compute the integral of p*p using the same recurrence and timing;
  - the result is driven on oSq_data with the same latency as oData.
- Undefined:
  - the extra logic is not built;
  - oSq_data is tied to 0;
  - oData timing is unchanged.

Decomposition:
- Shared package `iig_pkg` holds:
  - the state enum {IDLE, ACCUM};
  - default geometry constants;
  - width-derivation helpers for II_W and SQ_W via clog2.
- One natural sub-module: `iig_line_buffer`, a parametrised IMG_W x DW register array with combinational read and synchronous write. It is instantiated once, or twice when SQ_INTEGRAL_EN is defined.

Test Plan:
- IMG_W=4, IMG_H=3, iRun then 12 pixels all 1 back-to-back:
  - 12 writes;
  - addr 5 -> 4, addr 11 -> 12;
  - oFrame_done high only with addr 11.
- Same geometry, pixels 0..11 in raster order:
  - addr 3 -> 6, addr 7 -> 28, addr 11 -> 66.
  - With SQ_INTEGRAL_EN, sq at addr 11 -> 506.
- Defaults, 4800 pixels of 255:
  - final oData = 1224000 with no wrap;
  - with SQ_INTEGRAL_EN, final oSq_data = 312120000.
- iInput_ready pulses while IDLE and on the iRun cycle:
  - no oWrreq;
  - the first accepted pixel after iRun writes addr 0.
- iRun after 5 pixels of a 4x3 frame, then 12 pixels of 2:
  - addresses restart at 0;
  - addr 11 -> 24.
- iReset_n low for 1 cycle mid-frame:
  - next cycle all outputs 0, oBusy=0;
  - no writes until the next iRun.

Source files
------------

// File: rtl/iig_pkg.sv
// Shared types and geometry helpers for the integral-image generator.
// Widths derive from the frame size so that no integral value can overflow.
package iig_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam int DEF_IMG_W = 80;
    localparam int DEF_IMG_H = 60;
    localparam int DEF_PIX_W = 8;

    function automatic int addrWidth(input int imgW, input int imgH);
        return (imgW * imgH > 1) ? $clog2(imgW * imgH) : 1;
    endfunction

    function automatic int iiWidth(input int pixW, input int imgW, input int imgH);
        return pixW + addrWidth(imgW, imgH);
    endfunction

    function automatic int sqWidth(input int pixW, input int imgW, input int imgH);
        return 2 * pixW + addrWidth(imgW, imgH);
    endfunction

    localparam int DEF_ADDR_W = addrWidth(DEF_IMG_W, DEF_IMG_H);
    localparam int DEF_II_W   = iiWidth(DEF_PIX_W, DEF_IMG_W, DEF_IMG_H);
    localparam int DEF_SQ_W   = sqWidth(DEF_PIX_W, DEF_IMG_W, DEF_IMG_H);

endpackage

// File: rtl/integral_image_gen_if.sv
// Pixel-in / BRAM-write-out bundle of the integral-image generator.
// The generator uses the slave modport; the upstream stage and BRAM side use master.
interface integral_image_gen_if import iig_pkg::*; #(
    parameter int PIX_W  = DEF_PIX_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int II_W   = DEF_II_W,
    parameter int SQ_W   = DEF_SQ_W
);
    logic              iRun;
    logic              iInput_ready;
    logic [PIX_W-1:0]  iData;
    logic              oWrreq;
    logic [ADDR_W-1:0] oAddr;
    logic [II_W-1:0]   oData;
    logic [SQ_W-1:0]   oSq_data;
    logic              oBusy;
    logic              oFrame_done;

    modport master (
        output iRun, iInput_ready, iData,
        input  oWrreq, oAddr, oData, oSq_data, oBusy, oFrame_done
    );

    modport slave (
        input  iRun, iInput_ready, iData,
        output oWrreq, oAddr, oData, oSq_data, oBusy, oFrame_done
    );
endinterface

// File: rtl/iig_line_buffer.sv
// One-row line buffer: combinational read, synchronous write.
// Holds the integral values of the previous row, indexed by column.
module iig_line_buffer #(
    parameter int DEPTH = 80,
    parameter int DW    = 21,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          iClk,
    input  logic          we,
    input  logic [AW-1:0] wAddr,
    input  logic [DW-1:0] wData,
    input  logic [AW-1:0] rAddr,
    output logic [DW-1:0] rData
);
    logic [DW-1:0] mem [DEPTH];

    // NOTE: the array has no reset; row 0 never reads it, so stale contents are harmless
    // and leaving it unreset lets it map onto plain storage.
    always_ff @(posedge iClk) begin
        if (we) mem[wAddr] <= wData;
    end

    assign rData = mem[rAddr];
endmodule

// File: rtl/integral_image_gen.sv
// Raster-order integral-image generator with one-cycle write latency.
// Optional squared integral for variance normalisation: define SQ_INTEGRAL_EN.
module integral_image_gen import iig_pkg::*; #(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int PIX_W  = DEF_PIX_W,
    parameter int ADDR_W = addrWidth(IMG_W, IMG_H),
    parameter int II_W   = PIX_W + ADDR_W,
    parameter int SQ_W   = 2 * PIX_W + ADDR_W
) (
    input logic                iClk,
    input logic                iReset_n,
    integral_image_gen_if.slave io
);
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    state_t            state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] pixAddr;
    logic [II_W-1:0]   rowSum;
    logic [II_W-1:0]   rs, above, ii, lbRd;
    logic              accept, lastPix;

    // iRun takes priority over a pixel arriving in the same cycle.
    assign accept  = (state == ACCUM) && io.iInput_ready && !io.iRun;
    assign lastPix = (col == COL_W'(IMG_W - 1)) && (row == ROW_W'(IMG_H - 1));

    always_comb begin
        rs    = ((col == '0) ? '0 : rowSum) + II_W'(io.iData);
        above = (row == '0) ? '0 : lbRd;
        ii    = rs + above;
    end

    iig_line_buffer #(.DEPTH(IMG_W), .DW(II_W), .AW(COL_W)) uLineBuf (
        .iClk  (iClk),
        .we    (accept),
        .wAddr (col),
        .wData (ii),
        .rAddr (col),
        .rData (lbRd)
    );

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            state          <= IDLE;
            col            <= '0;
            row            <= '0;
            pixAddr        <= '0;
            rowSum         <= '0;
            io.oWrreq      <= 1'b0;
            io.oAddr       <= '0;
            io.oData       <= '0;
            io.oBusy       <= 1'b0;
            io.oFrame_done <= 1'b0;
        end else begin
            io.oWrreq      <= accept;
            io.oFrame_done <= accept && lastPix;
            if (accept) begin
                io.oAddr <= pixAddr;
                io.oData <= ii;
                rowSum   <= rs;
            end

            if (io.iRun) begin
                state    <= ACCUM;
                io.oBusy <= 1'b1;
                col      <= '0;
                row      <= '0;
                pixAddr  <= '0;
                rowSum   <= '0;
            end else if (accept) begin
                if (lastPix) begin
                    state    <= IDLE;
                    io.oBusy <= 1'b0;
                    col      <= '0;
                    row      <= '0;
                    pixAddr  <= '0;
                end else begin
                    pixAddr <= pixAddr + 1'b1;
                    if (col == COL_W'(IMG_W - 1)) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
            end
        end
    end

`ifdef SQ_INTEGRAL_EN
    logic [2*PIX_W-1:0] pixSq;
    logic [SQ_W-1:0]    sqRowSum, sqRs, sqAbove, sqIi, sqLbRd;

    always_comb begin
        pixSq   = (2 * PIX_W)'(io.iData) * (2 * PIX_W)'(io.iData);
        sqRs    = ((col == '0) ? '0 : sqRowSum) + SQ_W'(pixSq);
        sqAbove = (row == '0) ? '0 : sqLbRd;
        sqIi    = sqRs + sqAbove;
    end

    iig_line_buffer #(.DEPTH(IMG_W), .DW(SQ_W), .AW(COL_W)) uSqLineBuf (
        .iClk  (iClk),
        .we    (accept),
        .wAddr (col),
        .wData (sqIi),
        .rAddr (col),
        .rData (sqLbRd)
    );

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            sqRowSum    <= '0;
            io.oSq_data <= '0;
        end else if (io.iRun) begin
            sqRowSum <= '0;
        end else if (accept) begin
            sqRowSum    <= sqRs;
            io.oSq_data <= sqIi;
        end
    end
`else
    assign io.oSq_data = '0;
`endif

endmodule

// File: tb/tb_integral_image_gen.sv
// Scoreboard bench: a 4x3 instance checked write-by-write against rectangle sums,
// plus a default-geometry instance checked on its final full-scale word.
`timescale 1ns/1ps
module tb_integral_image_gen;
    import iig_pkg::*;

    localparam int SW = 4, SH = 3, S_ADDR = 4, S_II = 12, S_SQ = 20;
    localparam int BW = 80, BH = 60;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    integral_image_gen_if #(.PIX_W(8), .ADDR_W(S_ADDR), .II_W(S_II), .SQ_W(S_SQ)) sIf ();
    integral_image_gen_if #(.PIX_W(8), .ADDR_W(13), .II_W(21), .SQ_W(29)) bIf ();

    integral_image_gen #(.IMG_W(SW), .IMG_H(SH), .PIX_W(8), .ADDR_W(S_ADDR),
                         .II_W(S_II), .SQ_W(S_SQ)) uSmall (
        .iClk(clk), .iReset_n(rstN), .io(sIf.slave));

    integral_image_gen #(.IMG_W(BW), .IMG_H(BH), .PIX_W(8), .ADDR_W(13),
                         .II_W(21), .SQ_W(29)) uBig (
        .iClk(clk), .iReset_n(rstN), .io(bIf.slave));

    typedef struct {
        int     addr;
        longint data;
        longint sq;
        bit     last;
    } exp_t;

    exp_t   sbQ[$];
    int     nCompared = 0, nMismatched = 0;
    int     mImg[SH][SW];
    int     mRow, mCol;
    longint capData[SW*SH], capSq[SW*SH];
    int     sWrites, sDones, sDoneAddr;
    int     bWrites, bDones;
    longint bLastData, bLastSq;

    // Small-instance monitor: every write is popped and compared against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (sIf.oWrreq === 1'b1) begin
            sWrites++;
            capData[int'(sIf.oAddr) % (SW*SH)] = longint'(sIf.oData);
            capSq[int'(sIf.oAddr) % (SW*SH)]   = longint'(sIf.oSq_data);
            if (sIf.oFrame_done === 1'b1) begin
                sDones++;
                sDoneAddr = int'(sIf.oAddr);
            end
            nCompared++;
            if (sbQ.size() == 0) begin
                nMismatched++;
                $display("FAIL unexpected_write: got addr=%0d data=%0d, required no write",
                         sIf.oAddr, sIf.oData);
            end else begin
                e = sbQ.pop_front();
                if (sIf.oAddr !== S_ADDR'(e.addr) || sIf.oData !== S_II'(e.data) ||
                    sIf.oSq_data !== S_SQ'(e.sq) || sIf.oFrame_done !== e.last ||
                    sIf.oBusy !== !e.last) begin
                    nMismatched++;
                    $display("FAIL write: got addr=%0d data=%0d sq=%0d done=%0b busy=%0b, required addr=%0d data=%0d sq=%0d done=%0b busy=%0b",
                             sIf.oAddr, sIf.oData, sIf.oSq_data, sIf.oFrame_done, sIf.oBusy,
                             e.addr, e.data, e.sq, e.last, !e.last);
                end
            end
        end else begin
            nCompared++;
            if (sIf.oFrame_done !== 1'b0) begin
                nMismatched++;
                $display("FAIL done_without_write: got oFrame_done=%b, required 0", sIf.oFrame_done);
            end
        end
    end

    always @(negedge clk) begin
        if (bIf.oWrreq === 1'b1) begin
            bWrites++;
            bLastData = longint'(bIf.oData);
            bLastSq   = longint'(bIf.oSq_data);
            if (bIf.oFrame_done === 1'b1) bDones++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearCapture();
        for (int i = 0; i < SW*SH; i++) begin
            capData[i] = -1;
            capSq[i]   = -1;
        end
        sWrites = 0;
        sDones  = 0;
        sDoneAddr = -1;
    endtask

    task automatic runSmall();
        sIf.iRun = 1'b1;
        step();
        sIf.iRun = 1'b0;
        mRow = 0;
        mCol = 0;
    endtask

    // Expected value is the direct rectangle sum over all raster-earlier pixels.
    task automatic sendSmall(input int p);
        exp_t e;
        longint s, q;
        mImg[mRow][mCol] = p;
        s = 0;
        q = 0;
        for (int r = 0; r <= mRow; r++)
            for (int c = 0; c <= mCol; c++) begin
                s += mImg[r][c];
                q += mImg[r][c] * mImg[r][c];
            end
        e.addr = mRow * SW + mCol;
        e.data = s;
`ifdef SQ_INTEGRAL_EN
        e.sq = q;
`else
        e.sq = 0;
`endif
        e.last = (e.addr == SW*SH - 1);
        sbQ.push_back(e);
        if (mCol == SW - 1) begin
            mCol = 0;
            mRow = (mRow == SH - 1) ? 0 : mRow + 1;
        end else begin
            mCol++;
        end
        sIf.iInput_ready = 1'b1;
        sIf.iData = 8'(p);
        step();
        sIf.iInput_ready = 1'b0;
    endtask

    task automatic drain();
        repeat (3) step();
        nCompared++;
        if (sbQ.size() != 0) begin
            nMismatched++;
            $display("FAIL drain: got %0d writes outstanding, required 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic expectVal(input string name, input longint got, input longint req);
        nCompared++;
        if (got !== req) begin
            nMismatched++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (3) step();
        nCompared++;
        if ({sIf.oWrreq, sIf.oAddr, sIf.oData, sIf.oSq_data, sIf.oBusy, sIf.oFrame_done} !== '0 ||
            {bIf.oWrreq, bIf.oAddr, bIf.oData, bIf.oSq_data, bIf.oBusy, bIf.oFrame_done} !== '0) begin
            nMismatched++;
            $display("FAIL reset_outputs: got small wr=%b addr=%0d data=%0d busy=%b, required all 0",
                     sIf.oWrreq, sIf.oAddr, sIf.oData, sIf.oBusy);
        end
        rstN = 1'b1;
        step();
    endtask

    task automatic test_ones();
        clearCapture();
        runSmall();
        for (int i = 0; i < SW*SH; i++) sendSmall(1);
        drain();
        expectVal("ones_writes", sWrites, 12);
        expectVal("ones_addr5", capData[5], 4);
        expectVal("ones_addr11", capData[11], 12);
        expectVal("ones_done_count", sDones, 1);
        expectVal("ones_done_addr", sDoneAddr, 11);
        expectVal("ones_busy_after", longint'(sIf.oBusy), 0);
    endtask

    task automatic test_ramp();
        clearCapture();
        runSmall();
        for (int i = 0; i < SW*SH; i++) sendSmall(i);
        drain();
        expectVal("ramp_addr3", capData[3], 6);
        expectVal("ramp_addr7", capData[7], 28);
        expectVal("ramp_addr11", capData[11], 66);
`ifdef SQ_INTEGRAL_EN
        expectVal("ramp_sq11", capSq[11], 506);
`else
        expectVal("ramp_sq11", capSq[11], 0);
`endif
    endtask

    task automatic test_idle_drop();
        clearCapture();
        sIf.iData = 8'd7;
        for (int i = 0; i < 3; i++) begin
            sIf.iInput_ready = 1'b1;
            step();
            sIf.iInput_ready = 1'b0;
            step();
        end
        sIf.iRun = 1'b1;
        sIf.iInput_ready = 1'b1;
        sIf.iData = 8'd9;
        step();
        sIf.iRun = 1'b0;
        sIf.iInput_ready = 1'b0;
        mRow = 0;
        mCol = 0;
        step();
        expectVal("drop_no_writes", sWrites, 0);
        expectVal("drop_busy", longint'(sIf.oBusy), 1);
        for (int i = 0; i < SW*SH; i++) sendSmall(3);
        drain();
        expectVal("drop_frame_writes", sWrites, 12);
    endtask

    task automatic test_restart();
        clearCapture();
        runSmall();
        for (int i = 0; i < 5; i++) sendSmall(1);
        runSmall();
        for (int i = 0; i < SW*SH; i++) sendSmall(2);
        drain();
        expectVal("restart_writes", sWrites, 17);
        expectVal("restart_addr11", capData[11], 24);
        expectVal("restart_done_count", sDones, 1);
    endtask

    task automatic test_reset_midframe();
        clearCapture();
        runSmall();
        for (int i = 0; i < 5; i++) sendSmall(3);
        rstN = 1'b0;
        step();
        nCompared++;
        if ({sIf.oWrreq, sIf.oAddr, sIf.oData, sIf.oSq_data, sIf.oBusy, sIf.oFrame_done} !== '0) begin
            nMismatched++;
            $display("FAIL midreset_outputs: got wr=%b addr=%0d data=%0d busy=%b done=%b, required all 0",
                     sIf.oWrreq, sIf.oAddr, sIf.oData, sIf.oBusy, sIf.oFrame_done);
        end
        rstN = 1'b1;
        sIf.iData = 8'd5;
        for (int i = 0; i < 4; i++) begin
            sIf.iInput_ready = 1'b1;
            step();
        end
        sIf.iInput_ready = 1'b0;
        step();
        expectVal("midreset_writes", sWrites, 5);
        expectVal("midreset_no_done", sDones, 0);
        runSmall();
        for (int i = 0; i < SW*SH; i++) sendSmall(i);
        drain();
        expectVal("midreset_rerun_addr11", capData[11], 66);
    endtask

    task automatic test_back_to_back_full();
        bWrites = 0;
        bDones  = 0;
        bLastData = -1;
        bLastSq   = -1;
        bIf.iRun = 1'b1;
        step();
        bIf.iRun = 1'b0;
        bIf.iData = 8'd255;
        bIf.iInput_ready = 1'b1;
        repeat (BW*BH) step();
        bIf.iInput_ready = 1'b0;
        repeat (3) step();
        expectVal("full_writes", bWrites, 4800);
        expectVal("full_last_data", bLastData, 1224000);
`ifdef SQ_INTEGRAL_EN
        expectVal("full_last_sq", bLastSq, 312120000);
`else
        expectVal("full_last_sq", bLastSq, 0);
`endif
        expectVal("full_done_count", bDones, 1);
        expectVal("full_busy_after", longint'(bIf.oBusy), 0);
    endtask

    initial begin
        rstN = 1'b0;
        sIf.iRun = 1'b0;
        sIf.iInput_ready = 1'b0;
        sIf.iData = '0;
        bIf.iRun = 1'b0;
        bIf.iInput_ready = 1'b0;
        bIf.iData = '0;
        sWrites = 0;
        sDones = 0;
        bWrites = 0;
        bDones = 0;

        test_reset();
        test_ones();
        test_ramp();
        test_idle_drop();
        test_restart();
        test_reset_midframe();
        test_back_to_back_full();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
